// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// Provides the FSM state enum, default parameter values and the helper
// that sizes the shared cycle counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } sup_state_t;

    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_GLITCH_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_CNT_W          = 8;

    // The counter must be able to hold TIMEOUT_CYCLES itself (it saturates
    // there), so size for max+1 rather than max.
    function automatic int cnt_width(input int hold_c, input int stable_c,
                                     input int glitch_c, input int timeout_c);
        int m;
        m = hold_c;
        if (stable_c > m)  m = stable_c;
        if (glitch_c > m)  m = glitch_c;
        if (timeout_c > m) m = timeout_c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment.
//   LOCK, LOSS_CLR        : towards the supervisor
//   SYS_RST_N, READY      : reset release / ready
//   LOSS_CNT, LOSS_STICKY : loss-of-lock status
//   LOCK_TIMEOUT, STATE   : timeout flag and debug state
// master = environment side, slave = supervisor side.
interface pll_lock_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             LOCK;
    logic             LOSS_CLR;
    logic             SYS_RST_N;
    logic             READY;
    logic [CNT_W-1:0] LOSS_CNT;
    logic             LOSS_STICKY;
    logic             LOCK_TIMEOUT;
    logic [2:0]       STATE;

    modport master (
        output LOCK, LOSS_CLR,
        input  SYS_RST_N, READY, LOSS_CNT, LOSS_STICKY, LOCK_TIMEOUT, STATE
    );

    modport slave (
        input  LOCK, LOSS_CLR,
        output SYS_RST_N, READY, LOSS_CNT, LOSS_STICKY, LOCK_TIMEOUT, STATE
    );
endinterface

// File: rtl/sync2_rstn.sv
// Two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : async reset, active-low (flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync2_rstn (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies PLL lock over a stable window, filters
// short dropouts, and drives the downstream reset release and status.
//   CLK   : supervisor clock
//   RST_N : async reset, active-low
//   bus   : LOCK / LOSS_CLR in; SYS_RST_N, READY, LOSS_CNT, LOSS_STICKY,
//           LOCK_TIMEOUT, STATE out
//
// state     | meaning
// HOLD      | downstream held in reset for HOLD_CYCLES
// WAIT_LOCK | waiting for lock, timeout counter running
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | released; short dropouts filtered
// LOST      | one-cycle loss marker, then HOLD
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int GLITCH_CYCLES  = DEF_GLITCH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input logic                  CLK,
    input logic                  RST_N,
    pll_lock_supervisor_if.slave bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, STABLE_CYCLES, GLITCH_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GLITCH_LAST  = CW'(GLITCH_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOSS_MAX  = {CNT_W{1'b1}};

    sup_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lock_s;
    logic             timeout_set;
    logic             loss_entry;
    logic             sys_rst_n_q;
    logic [CNT_W-1:0] loss_cnt_q;
    logic             loss_sticky_q;
    logic             lock_timeout_q;

    sync2_rstn u_lock_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (bus.LOCK),
        .q     (lock_s)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q != TIMEOUT_MAX) begin
                    // Saturates at TIMEOUT_MAX; the flag fires once on arrival.
                    cnt_d       = cnt_q + CW'(1);
                    timeout_set = (cnt_q == TIMEOUT_LAST);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == GLITCH_LAST) begin
                    state_d = ST_LOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOST: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    assign loss_entry = (state_q == ST_RUN) && (state_d == ST_LOST);

    // A loss in the same cycle as a clear wins: the clear is applied first,
    // then the increment, leaving a count of 1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            loss_cnt_q     <= '0;
            loss_sticky_q  <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            if (loss_entry) begin
                if (bus.LOSS_CLR)
                    loss_cnt_q <= CNT_W'(1);
                else if (loss_cnt_q != LOSS_MAX)
                    loss_cnt_q <= loss_cnt_q + CNT_W'(1);
                loss_sticky_q <= 1'b1;
            end else if (bus.LOSS_CLR) begin
                loss_cnt_q    <= '0;
                loss_sticky_q <= 1'b0;
            end

            if (timeout_set)
                lock_timeout_q <= 1'b1;
            else if (bus.LOSS_CLR)
                lock_timeout_q <= 1'b0;
        end
    end

    assign bus.SYS_RST_N    = sys_rst_n_q;
    assign bus.READY        = (state_q == ST_RUN);
    assign bus.LOSS_CNT     = loss_cnt_q;
    assign bus.LOSS_STICKY  = loss_sticky_q;
    assign bus.LOCK_TIMEOUT = lock_timeout_q;
    assign bus.STATE        = state_q;
endmodule
